// File: rtl/alu8_issuer_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, FSM states, flag bit positions.
package alu8_issuer_pkg;

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_AND   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_NOTA  = 4'd6;
  localparam logic [3:0] OP_ONES  = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_READ  = 4'd9;

  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Codes 0-7 are passed straight through to the ALU sel input.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

endpackage

// File: rtl/alu8_regfile.sv
// Small 8-bit register file: two asynchronous read ports, one synchronous write port.
module alu8_regfile #(
  parameter int         ADDR_W    = 2,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [7:0]        rdata1,
  output logic [7:0]        rdata2
);

  localparam int NREGS = 1 << ADDR_W;

  logic [7:0] mem [NREGS];

  // NOTE: this array is a handful of flops, not a RAM macro, so resetting every
  // entry is cheap and required; a real SRAM would have no reset path.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= RESET_VAL;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/alu8_cmd_issuer.sv
// Command issuer for the external combinational 8-bit ALU: accept, execute, respond.
module alu8_cmd_issuer
  import alu8_issuer_pkg::*;
#(
  parameter int         REG_ADDR_W    = 2,
  parameter logic [7:0] REG_RESET_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [REG_ADDR_W-1:0] cmd_rd,
  input  logic [REG_ADDR_W-1:0] cmd_rs1,
  input  logic [REG_ADDR_W-1:0] cmd_rs2,
  input  logic [7:0]            cmd_imm,
  output logic [2:0]            alu_sel,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  input  logic [7:0]            alu_y,
  input  logic                  alu_v,
  input  logic                  alu_z,
  input  logic                  alu_c,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [7:0]            res_data,
  output logic [2:0]            res_flags,
  output logic                  res_err
);

  state_e                state, state_nxt;
  logic [3:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [7:0]            imm_q;
  logic [7:0]            rf_rd1, rf_rd2;
  logic                  rf_we;
  logic [7:0]            rf_wd;

  alu8_regfile #(
    .ADDR_W    (REG_ADDR_W),
    .RESET_VAL (REG_RESET_VAL)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (rd_q),
    .wdata  (rf_wd),
    .raddr1 (cmd_rs1),
    .raddr2 (cmd_rs2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // NOTE: state and data registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    rf_we     = 1'b0;
    rf_wd     = alu_y;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = RESP;
        if (is_alu_op(op_q)) begin
          rf_we = 1'b1;
          rf_wd = alu_y;
        end else if (op_q == OP_LOAD) begin
          rf_we = 1'b1;
          rf_wd = imm_q;
        end
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured at accept; the ALU output is sampled while in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      alu_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      res_data  <= '0;
      res_flags <= '0;
      res_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            rd_q    <= cmd_rd;
            imm_q   <= cmd_imm;
            alu_a   <= rf_rd1;
            alu_b   <= rf_rd2;
            alu_sel <= is_alu_op(cmd_op) ? cmd_op[2:0] : 3'd0;
          end
        end
        EXEC: begin
          res_flags <= '0;
          res_err   <= 1'b0;
          if (is_alu_op(op_q)) begin
            res_data          <= alu_y;
            res_flags[FLAG_V] <= alu_v;
            res_flags[FLAG_Z] <= alu_z;
            res_flags[FLAG_C] <= alu_c;
          end else if (op_q == OP_LOAD) begin
            res_data          <= imm_q;
            res_flags[FLAG_Z] <= (imm_q == 8'h00);
          end else if (op_q == OP_READ) begin
            res_data <= alu_a;
          end else begin
            res_data <= 8'h00;
            res_err  <= 1'b1;
          end
        end
        RESP: begin
          if (res_ready) res_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu8_cmd_issuer.sv
// Self-checking bench for alu8_cmd_issuer with a behavioural ALU and register-file model.
module tb_alu8_cmd_issuer;

  localparam int NREGS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [7:0] cmd_imm;
  logic [2:0] alu_sel;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_v, alu_z, alu_c;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [2:0] res_flags;
  logic       res_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rf_m [NREGS];

  always #5 clk = ~clk;

  alu8_cmd_issuer #(
    .REG_ADDR_W    (2),
    .REG_RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs1   (cmd_rs1),
    .cmd_rs2   (cmd_rs2),
    .cmd_imm   (cmd_imm),
    .alu_sel   (alu_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .alu_v     (alu_v),
    .alu_z     (alu_z),
    .alu_c     (alu_c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_flags (res_flags),
    .res_err   (res_err)
  );

  // ALU behaviour from plain integer arithmetic; returns {v, z, c, y}.
  function automatic logic [10:0] alu_fn(input int sel, input int a, input int b);
    int r, sa, sb, s;
    logic v, c;
    logic [7:0] y;
    v  = 1'b0;
    c  = 1'b0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (sel)
      0: r = 0;
      1: r = a & b;
      2: r = a | b;
      3: r = a ^ b;
      4: begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      5: begin r = a - b; c = (r < 0);   s = sa - sb; v = (s > 127) || (s < -128); end
      6: r = 255 - a;
      default: r = 255;
    endcase
    r = r & 255;
    y = r[7:0];
    return {v, (r == 0), c, y};
  endfunction

  always_comb {alu_v, alu_z, alu_c, alu_y} = alu_fn(int'(alu_sel), int'(alu_a), int'(alu_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic junk_cmd();
    cmd_op  = 4'($urandom);
    cmd_rd  = 2'($urandom);
    cmd_rs1 = 2'($urandom);
    cmd_rs2 = 2'($urandom);
    cmd_imm = 8'($urandom);
  endtask

  // One command end to end: model update, accept, response checks, optional stall.
  task automatic do_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [7:0] imm, input int stall,
                        input string tag);
    logic [7:0]  ea, eb, edata;
    logic [2:0]  eflags, esel;
    logic        eerr;
    logic [10:0] r;
    int          n;
    ea     = rf_m[rs1];
    eb     = rf_m[rs2];
    esel   = 3'd0;
    eflags = 3'b000;
    eerr   = 1'b0;
    edata  = 8'h00;
    if (op < 4'd8) begin
      r      = alu_fn(int'(op), int'(ea), int'(eb));
      edata  = r[7:0];
      eflags = r[10:8];
      esel   = op[2:0];
      rf_m[rd] = edata;
    end else if (op == 4'd8) begin
      edata    = imm;
      eflags   = {1'b0, (imm == 8'h00), 1'b0};
      rf_m[rd] = imm;
    end else if (op == 4'd9) begin
      edata = ea;
    end else begin
      eerr = 1'b1;
    end

    n = 0;
    while (!cmd_ready && n < 10) begin @(posedge clk); #1; n++; end
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    junk_cmd();

    n = 0;
    while (!res_valid && n < 10) begin @(posedge clk); #1; n++; end
    check({tag, "_res_valid"}, res_valid, 1);
    check({tag, "_latency_ok"}, (n >= 1 && n <= 2), 1);
    check({tag, "_data"},  res_data,  edata);
    check({tag, "_flags"}, res_flags, eflags);
    check({tag, "_err"},   res_err,   eerr);
    check({tag, "_sel"},   alu_sel,   esel);
    check({tag, "_a"},     alu_a,     ea);
    check({tag, "_b"},     alu_b,     eb);
    check({tag, "_busy"},  cmd_ready, 0);

    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1;
      junk_cmd();
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, res_valid, 1);
      check({tag, "_stall_data"},  res_data,  edata);
      check({tag, "_stall_err"},   res_err,   eerr);
      check({tag, "_stall_busy"},  cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_done_valid"}, res_valid, 0);
    check({tag, "_done_err"},   res_err,   0);
    check({tag, "_done_ready"}, cmd_ready, 1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NREGS; i++) rf_m[i] = 8'h00;
  endtask

  initial begin
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    junk_cmd();
    apply_reset();

    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data",  res_data,  0);
    check("rst_res_flags", res_flags, 0);
    check("rst_res_err",   res_err,   0);
    check("rst_alu_sel",   alu_sel,   0);
    check("rst_alu_a",     alu_a,     0);
    check("rst_alu_b",     alu_b,     0);

    for (int i = 0; i < NREGS; i++) do_cmd(4'd9, 2'd0, 2'(i), 2'd0, 8'h00, 0, "rd_init");

    do_cmd(4'd8, 2'd1, 2'd0, 2'd0, 8'h05, 0, "ld_r1");
    do_cmd(4'd8, 2'd2, 2'd0, 2'd0, 8'h03, 0, "ld_r2");
    do_cmd(4'd5, 2'd3, 2'd1, 2'd2, 8'h00, 0, "sub");
    check("sub_value", res_data, 8'h02);
    do_cmd(4'd9, 2'd0, 2'd3, 2'd0, 8'h00, 0, "rd_r3");
    check("rd_r3_value", res_data, 8'h02);

    do_cmd(4'd8, 2'd0, 2'd0, 2'd0, 8'hA5, 0, "ld_r0");
    do_cmd(4'd3, 2'd0, 2'd0, 2'd0, 8'h00, 0, "xor_self");
    check("xor_self_z", res_flags[1], 1);
    do_cmd(4'd9, 2'd0, 2'd0, 2'd0, 8'h00, 0, "rd_r0");
    check("rd_r0_value", res_data, 8'h00);

    do_cmd(4'd8, 2'd1, 2'd0, 2'd0, 8'hF0, 0, "ld_f0");
    do_cmd(4'd8, 2'd2, 2'd0, 2'd0, 8'h3C, 0, "ld_3c");
    do_cmd(4'd1, 2'd3, 2'd1, 2'd2, 8'h00, 5, "and_stall");
    check("and_value", res_data, 8'h30);

    do_cmd(4'hC, 2'd1, 2'd2, 2'd3, 8'hEE, 0, "illegal");
    for (int i = 0; i < NREGS; i++) do_cmd(4'd9, 2'd0, 2'(i), 2'd0, 8'h00, 0, "rd_post_ill");

    // Reset while a LOAD is in EXEC: no response and no writeback.
    cmd_valid = 1'b1;
    cmd_op = 4'd8; cmd_rd = 2'd2; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_imm = 8'h77;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NREGS; i++) rf_m[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_valid", res_valid, 0);
      check("midrst_ready",    cmd_ready, 1);
      @(posedge clk); #1;
    end
    do_cmd(4'd9, 2'd0, 2'd2, 2'd0, 8'h00, 0, "rd_r2_after_rst");
    check("rd_r2_after_rst_value", res_data, 8'h00);

    for (int k = 0; k < 50; k++)
      do_cmd(4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)), "rand");
    for (int i = 0; i < NREGS; i++) do_cmd(4'd9, 2'd0, 2'(i), 2'd0, 8'h00, 0, "rd_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
